// File: rtl/sid_pwm_dac.sv
// PWM audio DAC for the SID mixer output: scales a signed sample by the master
// volume, double-buffers it as an 8-bit duty and plays one duty per PWM period.
module sid_pwm_dac #(
  parameter int SAMPLE_W = 12,
  parameter int PWM_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [3:0]                 volume,
  input  logic                       underrun_clr,
  output logic                       pwm_out,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int PROD_W = SAMPLE_W + 5;
  localparam logic [PWM_W-1:0]    CNT_MAX  = '1;
  localparam logic [PWM_W-1:0]    DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] BIAS     = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [PWM_W-1:0]         cnt;
  logic [PWM_W-1:0]         active_duty;
  logic [PWM_W-1:0]         pending_duty;
  logic                     pending_full;
  logic [PWM_W-1:0]         new_duty;
  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;
  logic [SAMPLE_W-1:0]      biased;
  logic                     accept;
  logic                     wrap;
  logic                     unused_bits;

  assign sample_ready = ena & ~pending_full;
  assign accept       = sample_valid & sample_ready;
  assign wrap         = (cnt == CNT_MAX);

  // Gain is (volume+1)/16; the product never exceeds +-2^(SAMPLE_W+3), so
  // PROD_W bits hold it and the rescaled value fits back into SAMPLE_W bits.
  always_comb begin
    sample_ext = PROD_W'(sample_in);
    gain       = PROD_W'({1'b0, volume}) + PROD_W'(1);
    prod       = sample_ext * gain;
    scaled     = prod >>> 4;
    biased     = scaled[SAMPLE_W-1:0] + BIAS;
    new_duty   = biased[SAMPLE_W-1 -: PWM_W];
  end

  assign unused_bits = ^{scaled[PROD_W-1:SAMPLE_W], biased[SAMPLE_W-PWM_W-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      active_duty  <= DUTY_MID;
      pending_duty <= DUTY_MID;
      pending_full <= 1'b0;
      pwm_out      <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else if (ena) begin
      cnt         <= cnt + PWM_W'(1);
      frame_start <= wrap;
      pwm_out     <= (cnt < active_duty);

      // A load and an accept cannot coincide: sample_ready is low while full.
      if (wrap && pending_full) begin
        active_duty  <= pending_duty;
        pending_full <= 1'b0;
      end else if (accept) begin
        pending_duty <= new_duty;
        pending_full <= 1'b1;
      end

      if (wrap && !pending_full)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sid_pwm_dac.sv
// Self-checking bench for sid_pwm_dac: a period-level reference model checked
// every cycle, plus literal high-cycle counts for known samples.
module tb_sid_pwm_dac;

  localparam int SAMPLE_W = 12;
  localparam int PWM_W    = 8;
  localparam int PERIOD   = 1 << PWM_W;
  localparam int HALF     = 1 << (SAMPLE_W - 1);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       ena;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;
  logic [3:0]                 volume;
  logic                       underrun_clr;
  logic                       pwm_out;
  logic                       frame_start;
  logic                       underrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  int m_cnt, m_pend_duty, m_active;
  bit m_pend_full, m_pwm, m_fs, m_under, m_last, m_accept;

  sid_pwm_dac #(.SAMPLE_W(SAMPLE_W), .PWM_W(PWM_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .volume       (volume),
    .underrun_clr (underrun_clr),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Duty from plain arithmetic: floor(sample*(vol+1)/16), re-biased, top bits.
  function automatic int duty_of(input int sample, input int vol);
    int p, s;
    p = sample * (vol + 1);
    s = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    return (s + HALF) / (1 << (SAMPLE_W - PWM_W));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_pend_full = 0; m_pend_duty = PERIOD / 2; m_active = PERIOD / 2;
      m_pwm = 0; m_fs = 0; m_under = 0;
    end else if (ena) begin
      m_last   = (m_cnt == PERIOD - 1);
      m_accept = sample_valid && !m_pend_full;
      m_pwm    = (m_cnt < m_active);
      m_fs     = m_last;
      if (m_last && !m_pend_full) m_under = 1;
      else if (underrun_clr)      m_under = 0;
      if (m_last && m_pend_full) begin
        m_active    = m_pend_duty;
        m_pend_full = 0;
      end else if (m_accept) begin
        m_pend_duty = duty_of(int'(sample_in), int'(volume));
        m_pend_full = 1;
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("sample_ready", sample_ready, ena && !m_pend_full);
      checkOutput("pwm_out", pwm_out, m_pwm);
      checkOutput("frame_start", frame_start, m_fs);
      checkOutput("underrun", underrun, m_under);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) break;
    end
    checkOutput("frame_wait", frame_start, 1'b1);
  endtask

  // Counts high cycles over one period starting at the current negedge.
  task automatic measure(input string name, input int expected);
    int highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      highs += int'(pwm_out);
      @(negedge clk);
    end
    checkOutput(name, highs, expected);
  endtask

  // Presents a sample and returns just after the accepting edge, valid still high.
  task automatic applyStimulus(input logic [SAMPLE_W-1:0] s, input logic [3:0] v);
    sample_in    = s;
    volume       = v;
    sample_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sample_ready === 1'b1) break;
    end
    checkOutput("accept_wait", sample_ready, 1'b1);
    step();
  endtask

  task automatic play_one(input string name, input logic [SAMPLE_W-1:0] s,
                          input logic [3:0] v, input int expected);
    step();
    underrun_clr = 1'b1;
    applyStimulus(s, v);
    underrun_clr = 1'b0;
    sample_valid = 1'b0;
    volume       = 4'd0;
    wait_frame();
    checkOutput({name, "_no_underrun"}, underrun, 1'b0);
    measure(name, expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; sample_in = 12'h7FF; sample_valid = 1'b1;
    volume = 4'd15; underrun_clr = 1'b0;
    #1;
    repeat (3) step();
    checking     = 1'b1;
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", sample_ready, 1'b1);
    checkOutput("reset_pwm", pwm_out, 1'b0);
    checkOutput("reset_frame", frame_start, 1'b0);
    checkOutput("reset_underrun", underrun, 1'b0);

    checkOutput("model_full_scale", duty_of(2047, 15), 255);
    checkOutput("model_neg_full", duty_of(-2048, 15), 0);
    checkOutput("model_vol7", duty_of(2047, 7), 191);

    wait_frame();
    checkOutput("idle_underrun", underrun, 1'b1);
    measure("idle_midscale", 128);

    play_one("max_duty", 12'h7FF, 4'd15, 255);
    play_one("min_duty", 12'h800, 4'd15, 0);
    play_one("vol7_duty", 12'h7FF, 4'd7, 191);
    play_one("neg_vol3", 12'hC18, 4'd3, 112);

    // Back-to-back samples with valid held high.
    step();
    underrun_clr = 1'b1;
    applyStimulus(12'h7FF, 4'd15);
    underrun_clr = 1'b0;
    applyStimulus(12'h800, 4'd15);
    sample_valid = 1'b0;
    wait_frame();
    checkOutput("b2b_no_underrun", underrun, 1'b0);
    measure("b2b_second", 0);
    checkOutput("b2b_underrun_after", underrun, 1'b1);

    // Clock enable low freezes everything and blocks acceptance.
    step();
    ena          = 1'b0;
    sample_in    = 12'h123;
    sample_valid = 1'b1;
    repeat (20) step();
    checkOutput("ready_when_disabled", sample_ready, 1'b0);
    ena          = 1'b1;
    sample_valid = 1'b0;
    repeat (5) step();

    // Reset at cnt=100 with a sample pending.
    wait_frame();
    step();
    applyStimulus(12'h400, 4'd15);
    sample_valid = 1'b0;
    repeat (98) step();
    rst_n        = 1'b0;
    sample_valid = 1'b1;
    step();
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready", sample_ready, 1'b1);
    checkOutput("rst_mid_underrun", underrun, 1'b0);
    checkOutput("rst_mid_frame", frame_start, 1'b0);
    measure("rst_mid_duty", 128);
    repeat (3) @(negedge clk);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_pwm_dac.md
SID_PWM_DAC -- requirements
Module: sid_pwm_dac

Interface
REQ-001 Parameter SAMPLE_W, default 12, signed sample width from the SID voice mixer.
REQ-002 Parameter PWM_W, default 8, PWM resolution; period = 2^PWM_W clocks.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ena  input  1  clock enable; low freezes all state.
REQ-006 sample_in  input  SAMPLE_W  signed two's-complement mixer sample.
REQ-007 sample_valid  input  1  sample_in is valid this cycle.
REQ-008 sample_ready  output  1  block can accept a sample this cycle.
REQ-009 volume  input  4  unsigned master volume; gain = (volume+1)/16.
REQ-010 underrun_clr  input  1  clears the underrun flag.
REQ-011 pwm_out  output  1  registered PWM audio bit to the pad.
REQ-012 frame_start  output  1  one-cycle pulse on the first cycle of each PWM period.
REQ-013 underrun  output  1  sticky flag: a period started with no new sample.

Function
REQ-014 The period counter cnt (PWM_W bits) SHALL increment by 1 each cycle with ena=1 and wrap from 2^PWM_W-1 to 0.
REQ-015 The block SHALL hold one pending entry (duty + full bit); sample_ready SHALL equal ena AND NOT pending_full (combinational).
REQ-016 The block SHALL accept a sample when sample_valid, sample_ready and ena are all 1, setting pending_full next cycle.
REQ-017 On accept, the pending duty SHALL be: p = sample_in * (volume+1) at SAMPLE_W+5 bits signed; s = p >>> 4 (arithmetic); u = s + 2^(SAMPLE_W-1) unsigned; duty = u[SAMPLE_W-1 : SAMPLE_W-PWM_W].
REQ-018 volume SHALL be sampled at accept time only; later changes do not affect a pending sample.
REQ-019 In the cycle with cnt = 2^PWM_W-1 and pending_full=1, active_duty SHALL load the pending duty and pending_full SHALL clear; sample_ready SHALL be 1 again from the next cycle.
REQ-020 In the cycle with cnt = 2^PWM_W-1 and pending_full=0, active_duty SHALL be kept and underrun SHALL set, even if a sample is accepted in that same cycle (that sample plays in the following period).
REQ-021 pwm_out SHALL register (cnt < active_duty), evaluated with the active_duty in effect for that cnt; duty 0 gives constant low, duty 2^PWM_W-1 gives high for all but one cycle per period.
REQ-022 frame_start SHALL be a registered pulse, high exactly in cycles where cnt = 0.
REQ-023 underrun_clr=1 SHALL clear underrun next cycle; a simultaneous set condition SHALL take priority (flag stays 1).
REQ-024 With ena=0, cnt, pending, active_duty, pwm_out, frame_start and underrun SHALL hold, and no sample is accepted.

Reset
REQ-025 With rst_n=0 at a clock edge: cnt=0, pending_full=0, active_duty=2^(PWM_W-1) (midscale silence), pwm_out=0, frame_start=0, underrun=0.
REQ-026 Reset SHALL take precedence over ena and over any handshake in the same cycle; a sample presented during reset is dropped.
REQ-027 After reset, sample_ready SHALL be 1 in the first cycle with ena=1.

Verification
REQ-028 Reset, ena=1, no samples -> pwm_out high 128 of every 256 cycles; underrun=1 after the first cnt=255 cycle; frame_start every 256 cycles.
REQ-029 sample_in=0x7FF, volume=15 -> duty 255; next period pwm_out high 255 cycles, low 1.
REQ-030 sample_in=0x800, volume=15 -> duty 0; pwm_out low for the whole next period.
REQ-031 sample_in=0x7FF, volume=7 -> s=1023, u=3071, duty 191; 191 high cycles per period.
REQ-032 Two samples offered back-to-back with valid held high -> first accepted, sample_ready low until the cnt=255 load, second accepted the cycle after; each plays exactly one period; no underrun.
REQ-033 rst_n low for one cycle at cnt=100 with a sample pending -> next cycle cnt=0, pending dropped, duty 128, underrun=0, sample_ready=1.
